// File: rtl/fetch_pkg.sv
// Shared fetch-side constants and the queue entry layout {pc, inst}.
package fetch_pkg;

  localparam int FQ_DEPTH  = 4;
  localparam int FQ_DATA_W = 32;
  localparam int FQ_PC_W   = 32;

  typedef struct packed {
    logic [FQ_PC_W-1:0]   pc;
    logic [FQ_DATA_W-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// IF -> queue -> ID handshake bundle. The queue sits on the slave modport;
// the fetch/decode environment sits on the master modport.
interface inst_fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int DATA_W = FQ_DATA_W,
  parameter int PC_W   = FQ_PC_W
);

  logic                       fs_valid;
  logic [PC_W-1:0]            fs_pc;
  logic [DATA_W-1:0]          fs_inst;
  logic                       fq_allow_in;
  logic                       ds_allow_in;
  logic                       fq_valid;
  logic [PC_W-1:0]            fq_pc;
  logic [DATA_W-1:0]          fq_inst;
  logic [$clog2(DEPTH+1)-1:0] fq_count;

  modport master (
    output fs_valid, fs_pc, fs_inst, ds_allow_in,
    input  fq_allow_in, fq_valid, fq_pc, fq_inst, fq_count
  );

  modport slave (
    input  fs_valid, fs_pc, fs_inst, ds_allow_in,
    output fq_allow_in, fq_valid, fq_pc, fq_inst, fq_count
  );

endinterface

// File: rtl/inst_fetch_queue_fq_storage.sv
// Entry array for the fetch queue: one synchronous write port and an
// asynchronous read mux selecting the head entry.
module fq_storage
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = FQ_DEPTH,
  parameter type entry_t = fq_entry_t,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  entry_t           wdata,
  input  logic [PTR_W-1:0] raddr,
  output entry_t           rdata
);

  entry_t mem [DEPTH];

  // NOTE: the array has no reset; occupancy lives in the pointers and count,
  // so stale contents are never presented and a reset tree here buys nothing.
  // NOTE: sequential state is always written with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between IF and ID. Optional same-cycle bypass of an
// empty queue is enabled with `define FETCH_QUEUE_BYPASS_EN.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int DATA_W = FQ_DATA_W,
  parameter int PC_W   = FQ_PC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  inst_fetch_queue_if.slave  fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             bypass;
  logic             push;
  logic             pop;
  entry_t           wr_entry;
  entry_t           head;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && fq.fs_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry consumed by ID this cycle must not also be stored.
  assign push = fq.fs_valid && !full && !flush && !(bypass && fq.ds_allow_in);
  assign pop  = !empty && fq.ds_allow_in && !flush;

  assign wr_entry = {fq.fs_pc, fq.fs_inst};

  fq_storage #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_storage (
    .clk   (clk),
    .we    (push && !reset),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointers wrap naturally at a power-of-two depth; count separates full from empty.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign fq.fq_allow_in = !full;
  assign fq.fq_valid    = !empty || bypass;
  assign fq.fq_pc       = bypass ? fq.fs_pc   : head.pc;
  assign fq.fq_inst     = bypass ? fq.fs_inst : head.inst;
  assign fq.fq_count    = count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue (DEPTH=4) against a queue-based model.
module tb_inst_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  inst_fetch_queue_if #(.DEPTH(DEPTH), .DATA_W(32), .PC_W(32)) bus ();

  inst_fetch_queue #(.DEPTH(DEPTH), .DATA_W(32), .PC_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .fq    (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  fq_entry_t model_q[$];

  function automatic bit exp_bypass();
`ifdef FETCH_QUEUE_BYPASS_EN
    return (model_q.size() == 0) && bus.fs_valid && !flush;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_valid();
    return (model_q.size() != 0) || exp_bypass();
  endfunction

  function automatic fq_entry_t exp_head();
    fq_entry_t e;
    e = '0;
    if (exp_bypass()) begin
      e.pc   = bus.fs_pc;
      e.inst = bus.fs_inst;
    end else if (model_q.size() != 0) begin
      e = model_q[0];
    end
    return e;
  endfunction

  task automatic drive(input bit v, input logic [31:0] pc, input bit ds);
    bus.fs_valid    = v;
    bus.fs_pc       = pc;
    bus.fs_inst     = $urandom;
    bus.ds_allow_in = ds;
  endtask

  // Advance one clock and apply the queue rules to the model.
  task automatic tick();
    bit        byp, do_pop, do_push;
    fq_entry_t e;
    byp     = exp_bypass();
    do_pop  = (model_q.size() != 0) && bus.ds_allow_in;
    do_push = bus.fs_valid && (model_q.size() != DEPTH) && !(byp && bus.ds_allow_in);
    e.pc    = bus.fs_pc;
    e.inst  = bus.fs_inst;
    @(posedge clk);
    if (reset || flush) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #3;
    n_tests++;
    if (bus.fq_count !== 3'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.fq_count);
    end
    n_tests++;
    if (bus.fq_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.fq_valid);
    end
    n_tests++;
    if (bus.fq_allow_in !== 1'b1) begin
      n_fail++; $display("FAIL reset_allow_in: got %b expected 1", bus.fq_allow_in);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'h1c00_0000 + 32'(4 * i), 1'b0);
      #3;
      n_tests++;
      if (bus.fq_allow_in !== 1'b1) begin
        n_fail++; $display("FAIL fill_allow_%0d: got %b expected 1", i, bus.fq_allow_in);
      end
      tick();
    end
    drive(1'b1, 32'h1c00_0010, 1'b0);
    #3;
    n_tests++;
    if (bus.fq_count !== 3'd4) begin
      n_fail++; $display("FAIL fill_count: got %0d expected 4", bus.fq_count);
    end
    n_tests++;
    if (bus.fq_allow_in !== 1'b0) begin
      n_fail++; $display("FAIL fill_full_allow: got %b expected 0", bus.fq_allow_in);
    end
    n_tests++;
    if (bus.fq_pc !== 32'h1c00_0000) begin
      n_fail++; $display("FAIL fill_head_pc: got %h expected 1c000000", bus.fq_pc);
    end
    tick();
    drive(1'b0, 32'h0, 1'b0);
    #3;
    n_tests++;
    if (bus.fq_count !== 3'd4) begin
      n_fail++; $display("FAIL fill_fifth_rejected: got count %0d expected 4", bus.fq_count);
    end
    tick();
  endtask

  task automatic test_drain();
    fq_entry_t e;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      #3;
      e = exp_head();
      n_tests++;
      if (bus.fq_valid !== 1'b1 || bus.fq_pc !== 32'h1c00_0000 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL drain_pc_%0d: got valid=%b pc=%h expected valid=1 pc=%h",
                 i, bus.fq_valid, bus.fq_pc, 32'h1c00_0000 + 32'(4 * i));
      end
      n_tests++;
      if (bus.fq_inst !== e.inst) begin
        n_fail++; $display("FAIL drain_inst_%0d: got %h expected %h", i, bus.fq_inst, e.inst);
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b1);
    #3;
    n_tests++;
    if (bus.fq_valid !== 1'b0 || bus.fq_count !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_empty: got valid=%b count=%0d expected valid=0 count=0",
               bus.fq_valid, bus.fq_count);
    end
  endtask

  task automatic test_steady();
    logic [31:0] base;
    base = 32'h1c00_0100;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, base + 32'(4 * i), 1'b0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, base + 32'(4 * (i + 2)), 1'b1);
      #3;
      n_tests++;
      if (bus.fq_count !== 3'd2 || bus.fq_pc !== base + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL steady_%0d: got count=%0d pc=%h expected count=2 pc=%h",
                 i, bus.fq_count, bus.fq_pc, base + 32'(4 * i));
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      tick();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1c00_0200 + 32'(4 * i), 1'b0);
      tick();
    end
    drive(1'b1, 32'h1c00_020c, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #3;
    n_tests++;
    if (bus.fq_count !== 3'd0 || bus.fq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: got count=%0d valid=%b expected count=0 valid=0",
               bus.fq_count, bus.fq_valid);
    end
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, 32'h1c00_0300 + 32'(4 * i), 1'b1);
      #3;
      if (bus.fq_valid === 1'b1) begin
        n_tests++;
        if (bus.fq_pc[31:8] === 24'h1c0002) begin
          n_fail++; $display("FAIL flush_leak_%0d: got pc=%h from a flushed entry", i, bus.fq_pc);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h1c00_0400 + 32'(4 * i), 1'b0);
      tick();
    end
    drive(1'b1, 32'h1c00_0408, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #3;
    n_tests++;
    if (bus.fq_count !== 3'd0 || bus.fq_valid !== 1'b0 || bus.fq_allow_in !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got count=%0d valid=%b allow=%b expected 0/0/1",
               bus.fq_count, bus.fq_valid, bus.fq_allow_in);
    end
    tick();
  endtask

  task automatic test_bypass();
    drive(1'b1, 32'h1c00_0010, 1'b1);
    #3;
`ifdef FETCH_QUEUE_BYPASS_EN
    n_tests++;
    if (bus.fq_valid !== 1'b1 || bus.fq_pc !== 32'h1c00_0010) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: got valid=%b pc=%h expected valid=1 pc=1c000010",
               bus.fq_valid, bus.fq_pc);
    end
    tick();
    drive(1'b0, 32'h0, 1'b0);
    #3;
    n_tests++;
    if (bus.fq_valid !== 1'b0 || bus.fq_count !== 3'd0) begin
      n_fail++;
      $display("FAIL bypass_not_stored: got valid=%b count=%0d expected 0/0",
               bus.fq_valid, bus.fq_count);
    end
    tick();
`else
    n_tests++;
    if (bus.fq_valid !== 1'b0) begin
      n_fail++; $display("FAIL nobypass_same_cycle: got valid=%b expected 0", bus.fq_valid);
    end
    tick();
    drive(1'b0, 32'h0, 1'b0);
    #3;
    n_tests++;
    if (bus.fq_valid !== 1'b1 || bus.fq_pc !== 32'h1c00_0010 || bus.fq_count !== 3'd1) begin
      n_fail++;
      $display("FAIL nobypass_next_cycle: got valid=%b pc=%h count=%0d expected 1/1c000010/1",
               bus.fq_valid, bus.fq_pc, bus.fq_count);
    end
    tick();
    #3;
    n_tests++;
    if (bus.fq_valid !== 1'b1 || bus.fq_pc !== 32'h1c00_0010) begin
      n_fail++;
      $display("FAIL nobypass_hold: got valid=%b pc=%h expected 1/1c000010",
               bus.fq_valid, bus.fq_pc);
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
`endif
  endtask

  task automatic test_random();
    logic [31:0] pc;
    fq_entry_t   e;
    pc = 32'h1c01_0000;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, pc, ($urandom % 3) != 0);
      flush = (($urandom % 25) == 0);
      reset = (($urandom % 60) == 0);
      pc    = pc + 32'd4;
      #3;
      if (!reset) begin
        n_tests++;
        if (bus.fq_count !== 3'(model_q.size()) || bus.fq_allow_in !== (model_q.size() != DEPTH)) begin
          n_fail++;
          $display("FAIL rand_count_%0d: got count=%0d allow=%b expected count=%0d",
                   i, bus.fq_count, bus.fq_allow_in, model_q.size());
        end
        n_tests++;
        if (bus.fq_valid !== exp_valid()) begin
          n_fail++; $display("FAIL rand_valid_%0d: got %b expected %b", i, bus.fq_valid, exp_valid());
        end
        if (exp_valid()) begin
          e = exp_head();
          n_tests++;
          if (bus.fq_pc !== e.pc || bus.fq_inst !== e.inst) begin
            n_fail++;
            $display("FAIL rand_head_%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                     i, bus.fq_pc, bus.fq_inst, e.pc, e.inst);
          end
        end
      end
      tick();
    end
    reset = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_steady();
    test_flush();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, at least 2.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter PC_W, default 32, PC width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  branch-taken cancel; discards all queued and incoming entries.
REQ-007 SHALL have port fs_valid  input  1  the IF stage offers an entry.
REQ-008 SHALL have port fs_pc  input  PC_W  PC of the offered entry.
REQ-009 SHALL have port fs_inst  input  DATA_W  instruction of the offered entry.
REQ-010 SHALL have port fq_allow_in  output  1  the queue accepts the offered entry this cycle.
REQ-011 SHALL have port ds_allow_in  input  1  the ID stage consumes the head entry this cycle.
REQ-012 SHALL have port fq_valid  output  1  the head entry is valid.
REQ-013 SHALL have port fq_pc  output  PC_W  PC of the head entry.
REQ-014 SHALL have port fq_inst  output  DATA_W  instruction of the head entry.
REQ-015 SHALL have port fq_count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-016 SHALL push when fs_valid && fq_allow_in && !flush, writing {fs_pc, fs_inst} at the write pointer.
REQ-017 SHALL drive fq_allow_in = (fq_count != DEPTH); a pop in the same cycle does not make a full queue accept.
REQ-018 SHALL pop when fq_valid && ds_allow_in && !flush; the read pointer advances by one.
REQ-019 SHALL drive fq_valid = (fq_count != 0) when no bypass applies; fq_pc and fq_inst come from the head entry.
REQ-020 SHALL give a pushed entry one cycle of latency: pushed at edge N, presented at the output with fq_valid=1 after edge N.
REQ-021 SHALL keep fq_count unchanged on a simultaneous push and pop, increment it on push only, and decrement it on pop only.
REQ-022 SHALL wrap both pointers modulo DEPTH without using extra wrap bits; fq_count distinguishes full from empty.
REQ-023 SHALL, on flush, clear pointers and fq_count to 0 at the next edge and ignore any push or pop in that cycle.
REQ-024 SHALL hold the head entry and all outputs stable while fq_valid=1 and ds_allow_in=0.
REQ-025 SHALL preserve FIFO order: entries leave in push order with no loss or duplication.

Reset
REQ-026 SHALL, on reset, clear the pointers and set fq_count=0, fq_valid=0 and fq_allow_in=1 from the next cycle.
REQ-027 SHALL let reset take priority over flush, push and pop; storage contents need not be cleared.
REQ-028 SHALL, on reset asserted mid-stream, discard every in-flight entry.

Configuration
REQ-029 SHALL, with macro FETCH_QUEUE_BYPASS_EN defined, pass fs_pc and fs_inst combinationally to the outputs when fq_count==0 && fs_valid && !flush; fq_valid is 1 and nothing is written if ds_allow_in=1.
REQ-030 SHALL, in the bypass case with ds_allow_in=0, push the entry normally.
REQ-031 SHALL, without FETCH_QUEUE_BYPASS_EN, use no bypass path; the minimum latency is one cycle (REQ-020).

Structure
REQ-032 SHALL take the default DEPTH, DATA_W and PC_W constants and the fq_entry_t typedef {pc, inst} from shared package fetch_pkg.
REQ-033 SHALL place the entry storage array and its read mux in one sub-module, fq_storage.

Verification (DEPTH=4)
REQ-034 SHALL cover fill: push 4 entries with ds_allow_in=0 -> fq_count=4, fq_allow_in=0, and a fifth push is not accepted.
REQ-035 SHALL cover drain: from full, ds_allow_in=1 for 4 cycles -> fq_pc outputs 0x1c000000, 0x1c000004, 0x1c000008, 0x1c00000c in order, then fq_valid=0.
REQ-036 SHALL cover steady flow: push and pop in the same cycle at count 2 -> count stays 2, and pointers wrap correctly across 10 cycles.
REQ-037 SHALL cover flush: flush=1 at count 3 together with fs_valid=1 -> next cycle fq_count=0 and fq_valid=0; the flushed PCs never appear at the output.
REQ-038 SHALL cover reset: reset=1 at count 2 mid-stream -> next cycle fq_count=0, fq_valid=0, fq_allow_in=1.
REQ-039 SHALL cover bypass: with FETCH_QUEUE_BYPASS_EN, an empty queue and fs_valid=1 with fs_pc=0x1c000010 -> fq_valid=1 and fq_pc=0x1c000010 in the same cycle; without the macro, these appear the next cycle.
